mi_nios_timer_mc: RTL and testbench

//  Multi-channel, parametrised Avalon-MM interval timer for the Nios II system.
//  NUM_CH independent down-counters, each with its own prescaler, one-shot/continuous

---
 rtl/mi_nios_timer_mc_pkg.sv | 29 ++
 rtl/mi_nios_timer_mc_if.sv | 13 +
 rtl/mi_nios_timer_mc_ch.sv | 110 +++++++++++
 rtl/mi_nios_timer_mc.sv | 82 ++++++++
 tb/tb_mi_nios_timer_mc.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mi_nios_timer_mc_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package mi_nios_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAPSHOT = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_COUNT    = 3'd5;
    localparam logic [2:0] REG_RSVD     = 3'd6;
    localparam logic [2:0] REG_PENDING  = 3'd7;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int STS_TO    = 0;
    localparam int STS_RUN   = 1;

    function automatic logic [31:0] status_word(input logic run, input logic to);
        logic [31:0] w;
        w          = '0;
        w[STS_RUN] = run;
        w[STS_TO]  = to;
        return w;
    endfunction

endpackage

// File: rtl/mi_nios_timer_mc_if.sv
// Avalon-MM slave bus bundle for the timer; readdata is driven by the slave.
interface mi_nios_timer_mc_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mi_nios_timer_mc_ch.sv
// One timer channel: prescaler, down-counter, control/status bits, period and snapshot.
module mi_nios_timer_ch
    import mi_nios_timer_pkg::*;
#(
    parameter int COUNT_W        = 32,
    parameter int PRESC_W        = 16,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        pending,
    output logic        timeout_p
);

    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] period_reg;
    logic [COUNT_W-1:0] snap_reg;
    logic [PRESC_W-1:0] presc_cnt_reg;
    logic [PRESC_W-1:0] prescale_reg;
    logic               run_reg;
    logic               to_reg;
    logic               cont_reg;
    logic               ito_reg;
    logic               pulse_reg;

    logic tick;
    logic expire;
    logic wr_status, wr_control, wr_period, wr_snap, wr_presc;

    assign tick       = run_reg && (presc_cnt_reg == '0);
    assign expire     = tick && (count_reg == '0);
    assign wr_status  = wr_en && (reg_sel == REG_STATUS);
    assign wr_control = wr_en && (reg_sel == REG_CONTROL);
    assign wr_period  = wr_en && (reg_sel == REG_PERIOD);
    assign wr_snap    = wr_en && (reg_sel == REG_SNAPSHOT);
    assign wr_presc   = wr_en && (reg_sel == REG_PRESCALE);

    // Later assignments override earlier ones: a timeout beats a status clear,
    // and a PERIOD write beats the running count update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= COUNT_W'(DEFAULT_PERIOD);
            period_reg    <= COUNT_W'(DEFAULT_PERIOD);
            snap_reg      <= '0;
            presc_cnt_reg <= '0;
            prescale_reg  <= '0;
            run_reg       <= 1'b0;
            to_reg        <= 1'b0;
            cont_reg      <= 1'b0;
            ito_reg       <= 1'b0;
            pulse_reg     <= 1'b0;
        end else begin
            pulse_reg <= expire;
            if (run_reg)
                presc_cnt_reg <= (presc_cnt_reg == '0) ? prescale_reg
                                                       : presc_cnt_reg - PRESC_W'(1);
            if (tick)
                count_reg <= expire ? period_reg : count_reg - COUNT_W'(1);
            if (wr_status)
                to_reg <= 1'b0;
            if (expire) begin
                to_reg <= 1'b1;
                if (!cont_reg)
                    run_reg <= 1'b0;
            end
            if (wr_control) begin
                ito_reg  <= wdata[CTL_ITO];
                cont_reg <= wdata[CTL_CONT];
                if (wdata[CTL_STOP])
                    run_reg <= 1'b0;
                else if (wdata[CTL_START])
                    run_reg <= 1'b1;
            end
            if (wr_period) begin
                period_reg    <= wdata[COUNT_W-1:0];
                count_reg     <= wdata[COUNT_W-1:0];
                run_reg       <= 1'b0;
                presc_cnt_reg <= '0;
            end
            if (wr_snap)
                snap_reg <= count_reg;
            if (wr_presc)
                prescale_reg <= wdata[PRESC_W-1:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS:   rd_data = status_word(run_reg, to_reg);
            REG_CONTROL: begin
                rd_data[CTL_ITO]  = ito_reg;
                rd_data[CTL_CONT] = cont_reg;
            end
            REG_PERIOD:   rd_data = 32'(period_reg);
            REG_SNAPSHOT: rd_data = 32'(snap_reg);
            REG_PRESCALE: rd_data = 32'(prescale_reg);
            REG_COUNT:    rd_data = 32'(count_reg);
            default:      rd_data = '0;
        endcase
    end

    assign pending   = to_reg & ito_reg;
    assign timeout_p = pulse_reg;

endmodule

// File: rtl/mi_nios_timer_mc.sv
// Multi-channel Avalon-MM interval timer: address decode, channel array, read mux, irq.
module mi_nios_timer_mc
    import mi_nios_timer_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int COUNT_W        = 32,
    parameter int PRESC_W        = 16,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic                clk,
    input  logic                reset_n,
    mi_nios_timer_mc_if.slave   bus,
    output logic                irq,
    output logic [NUM_CH-1:0]   timeout_p
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = 3 + $clog2(NUM_CH);

    logic [2:0]        reg_sel;
    logic [CH_W-1:0]   ch_idx;
    logic              bus_wr;
    logic              bus_rd;
    logic [31:0]       ch_rd [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [31:0]       rd_next;
    logic [31:0]       readdata_reg;

    assign reg_sel = bus.address[2:0];
    assign bus_wr  = bus.chipselect && !bus.write_n;
    assign bus_rd  = bus.chipselect && bus.write_n;

    generate
        if (NUM_CH > 1) begin : g_multi
            assign ch_idx = bus.address[ADDR_W-1:3];
        end else begin : g_single
            assign ch_idx = '0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ch_wr;
            assign ch_wr = bus_wr && (int'(ch_idx) == gi);

            mi_nios_timer_ch #(
                .COUNT_W       (COUNT_W),
                .PRESC_W       (PRESC_W),
                .DEFAULT_PERIOD(DEFAULT_PERIOD)
            ) u_ch (
                .clk      (clk),
                .reset_n  (reset_n),
                .wr_en    (ch_wr),
                .reg_sel  (reg_sel),
                .wdata    (bus.writedata),
                .rd_data  (ch_rd[gi]),
                .pending  (pending[gi]),
                .timeout_p(timeout_p[gi])
            );
        end
    endgenerate

    // A channel index with no matching channel leaves rd_next at zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_idx) == i)
                rd_next = (reg_sel == REG_PENDING) ? 32'(pending) : ch_rd[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_reg <= '0;
        else
            readdata_reg <= bus_rd ? rd_next : '0;
    end

    assign bus.readdata = readdata_reg;
    assign irq          = |pending;

endmodule

// File: tb/tb_mi_nios_timer_mc.sv
// Bench for mi_nios_timer_mc: register vector table, read scoreboard, timing sequences.
module tb_mi_nios_timer_mc;
    import mi_nios_timer_pkg::*;

    localparam int NUM_CH = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              irq;
    logic [NUM_CH-1:0] timeout_p;

    mi_nios_timer_mc_if #(.ADDR_W(4)) bus ();

    mi_nios_timer_mc #(
        .NUM_CH(NUM_CH), .COUNT_W(32), .PRESC_W(16), .DEFAULT_PERIOD(49999)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .irq      (irq),
        .timeout_p(timeout_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          ch;
        logic [2:0]  rg;
        logic [31:0] data;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          pcnt     [NUM_CH];
    int          last_cyc [NUM_CH];
    int          prev_cyc [NUM_CH];
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_capture = 1'b0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rd_capture <= bus.chipselect && bus.write_n;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Pulse bookkeeping and read-data scoreboard, sampled on the falling edge.
    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            pcnt[i] = 0; last_cyc[i] = 0; prev_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (timeout_p[i] === 1'b1) begin
                    prev_cyc[i] = last_cyc[i];
                    last_cyc[i] = cyc;
                    pcnt[i]++;
                end
            end
            if (rd_capture) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_read: got %0h expected no read", bus.readdata);
                end else begin
                    logic [31:0] e;
                    string       nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    $display("read  %s data=%0h", nm, bus.readdata);
                    check(nm, bus.readdata, e);
                end
            end
        end
    end

    task automatic bus_write(input int ch, input logic [2:0] rg, input logic [31:0] d);
        bus.address    = {ch[0], rg};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        $display("write ch%0d reg%0d data=%0h", ch, rg, d);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input logic [2:0] rg, input logic [31:0] e, input string nm);
        bus.address    = {ch[0], rg};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_pulses(input int ch, input int n, input int limit, input string nm);
        int target = pcnt[ch] + n;
        int k      = 0;
        while (pcnt[ch] < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (pcnt[ch] < target) begin
            n_vec++; n_bad++;
            $display("FAIL %s: got %0d pulses expected %0d within %0d clks", nm,
                     pcnt[ch] - target + n, n, limit);
        end
    endtask

    initial begin
        int p0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state and register read/write behaviour
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_timeout_p", 32'(timeout_p), 32'd0);
        tbl.push_back('{1'b0, 0, REG_PERIOD,   32'd49999});
        tbl.push_back('{1'b0, 0, REG_STATUS,   32'd0});
        tbl.push_back('{1'b0, 0, REG_COUNT,    32'd49999});
        tbl.push_back('{1'b0, 0, REG_CONTROL,  32'd0});
        tbl.push_back('{1'b0, 0, REG_PRESCALE, 32'd0});
        tbl.push_back('{1'b0, 0, REG_SNAPSHOT, 32'd0});
        tbl.push_back('{1'b0, 0, REG_RSVD,     32'd0});
        tbl.push_back('{1'b0, 0, REG_PENDING,  32'd0});
        tbl.push_back('{1'b0, 1, REG_PERIOD,   32'd49999});
        tbl.push_back('{1'b0, 1, REG_COUNT,    32'd49999});
        tbl.push_back('{1'b1, 1, REG_PRESCALE, 32'h0001_2345});
        tbl.push_back('{1'b0, 1, REG_PRESCALE, 32'h0000_2345});
        tbl.push_back('{1'b1, 1, REG_CONTROL,  32'h0000_000F});
        tbl.push_back('{1'b0, 1, REG_CONTROL,  32'd3});
        tbl.push_back('{1'b0, 1, REG_STATUS,   32'd0});
        tbl.push_back('{1'b1, 1, REG_CONTROL,  32'h0000_000C});
        tbl.push_back('{1'b0, 1, REG_STATUS,   32'd0});
        tbl.push_back('{1'b0, 1, REG_CONTROL,  32'd0});
        tbl.push_back('{1'b1, 1, REG_PRESCALE, 32'd0});
        tbl.push_back('{1'b1, 1, REG_SNAPSHOT, 32'd0});
        tbl.push_back('{1'b0, 1, REG_SNAPSHOT, 32'd49999});
        tbl.push_back('{1'b1, 1, REG_PERIOD,   32'd7});
        tbl.push_back('{1'b0, 1, REG_COUNT,    32'd7});
        tbl.push_back('{1'b0, 0, REG_COUNT,    32'd49999});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr)
                bus_write(tbl[i].ch, tbl[i].rg, tbl[i].data);
            else
                bus_read(tbl[i].ch, tbl[i].rg, tbl[i].data, $sformatf("tbl%0d", i));
        end
        @(negedge clk);

        // Continuous ch0, period 5 clks, irq set and cleared
        bus_write(0, REG_PERIOD, 32'd4);
        bus_write(0, REG_PRESCALE, 32'd0);
        bus_write(0, REG_CONTROL, 32'h7);
        wait_pulses(0, 1, 20, "t2_first_pulse");
        check("t2_irq_set", 32'(irq), 32'd1);
        wait_pulses(0, 1, 20, "t2_second_pulse");
        check("t2_interval_a", 32'(last_cyc[0] - prev_cyc[0]), 32'd5);
        bus_write(0, REG_STATUS, 32'd0);
        check("t2_irq_clear", 32'(irq), 32'd0);
        wait_pulses(0, 1, 20, "t2_third_pulse");
        check("t2_interval_b", 32'(last_cyc[0] - prev_cyc[0]), 32'd5);
        check("t2_irq_again", 32'(irq), 32'd1);
        bus_write(0, REG_CONTROL, 32'h8);
        bus_write(0, REG_STATUS, 32'd0);
        check("t2_irq_off", 32'(irq), 32'd0);

        // One-shot ch1 with prescaler
        p0 = pcnt[1];
        bus_write(1, REG_PERIOD, 32'd2);
        bus_write(1, REG_PRESCALE, 32'd3);
        bus_write(1, REG_CONTROL, 32'h4);
        repeat (40) @(negedge clk);
        check("t3_pulse_count", 32'(pcnt[1] - p0), 32'd1);
        check("t3_irq_masked", 32'(irq), 32'd0);
        bus_read(1, REG_STATUS, 32'd1, "t3_status");
        bus_read(1, REG_COUNT, 32'd2, "t3_count");
        bus_write(1, REG_STATUS, 32'd0);
        bus_write(1, REG_PRESCALE, 32'd0);

        // Two channels running independently
        bus_write(0, REG_PERIOD, 32'd3);
        bus_write(1, REG_PERIOD, 32'd6);
        bus_write(0, REG_CONTROL, 32'h7);
        bus_write(1, REG_CONTROL, 32'h7);
        wait_pulses(1, 2, 40, "t4_ch1_pulses");
        check("t4_ch1_interval", 32'(last_cyc[1] - prev_cyc[1]), 32'd7);
        check("t4_ch0_interval", 32'(last_cyc[0] - prev_cyc[0]), 32'd4);
        bus_write(0, REG_CONTROL, 32'h9);
        bus_read(0, REG_PENDING, 32'd3, "t4_pending_ch0");
        bus_read(1, REG_PENDING, 32'd3, "t4_pending_ch1");
        bus_write(0, REG_STATUS, 32'd0);
        bus_read(0, REG_PENDING, 32'd2, "t4_pending_after");
        @(negedge clk);
        check("t4_irq_still", 32'(irq), 32'd1);
        bus_write(1, REG_CONTROL, 32'h8);
        bus_write(1, REG_STATUS, 32'd0);
        check("t4_irq_off", 32'(irq), 32'd0);

        // PERIOD write while running stops the channel and reloads the count
        bus_write(0, REG_PERIOD, 32'd100);
        bus_write(0, REG_CONTROL, 32'h4);
        repeat (5) @(negedge clk);
        bus_write(0, REG_PERIOD, 32'd50);
        bus_read(0, REG_STATUS, 32'd0, "t5_status");
        bus_read(0, REG_COUNT, 32'd50, "t5_count");

        // STATUS write on the exact timeout clock keeps TO set
        bus_write(0, REG_PERIOD, 32'd3);
        bus_write(0, REG_CONTROL, 32'h7);
        repeat (3) @(negedge clk);
        bus_write(0, REG_STATUS, 32'd0);
        bus_read(0, REG_STATUS, 32'd3, "t6_status_set_wins");
        bus_write(0, REG_CONTROL, 32'h8);
        bus_write(0, REG_STATUS, 32'd0);

        // Snapshot at count 7 while the counter keeps running
        bus_write(0, REG_PERIOD, 32'd20);
        bus_write(0, REG_CONTROL, 32'h4);
        repeat (13) @(negedge clk);
        bus_write(0, REG_SNAPSHOT, 32'd0);
        bus_read(0, REG_SNAPSHOT, 32'd7, "t6_snapshot");
        bus_read(0, REG_COUNT, 32'd5, "t6_count_live");
        bus_write(0, REG_PERIOD, 32'd20);

        // Asynchronous reset in the middle of a count
        bus_write(0, REG_PERIOD, 32'd3);
        bus_write(0, REG_CONTROL, 32'h7);
        repeat (6) @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_irq", 32'(irq), 32'd0);
        check("rst_async_pulse", 32'(timeout_p), 32'd0);
        check("rst_async_rdata", bus.readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(0, REG_COUNT, 32'd49999, "rst2_count");
        bus_read(0, REG_STATUS, 32'd0, "rst2_status");
        bus_read(0, REG_CONTROL, 32'd0, "rst2_control");
        bus_read(0, REG_PERIOD, 32'd49999, "rst2_period");
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
